// File: rtl/keypad_scanner.sv
// 4x3 keypad front end: rotates the row drive, synchronizes the columns, debounces
// one key at a time and presents held row/column levels plus a one-cycle key event.
module keypad_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic       key_down,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  logic [1:0]    state;
  logic [DW-1:0] dwell;
  logic [BW-1:0] deb;
  logic [2:0]    col_meta;
  logic [2:0]    col_s;
  logic [3:0]    cap_row;
  logic [2:0]    cap_col;

  function automatic logic [3:0] rotl(input logic [3:0] r);
    rotl = {r[2:0], r[3]};
  endfunction

  function automatic logic [3:0] encode(input logic [3:0] r, input logic [2:0] c);
    logic [3:0] ci;
    ci = c[0] ? 4'd0 : (c[1] ? 4'd1 : 4'd2);
    case (r)
      4'b0001: encode = 4'd1 + ci;
      4'b0010: encode = 4'd4 + ci;
      4'b0100: encode = 4'd7 + ci;
      default: encode = c[0] ? 4'hA : (c[1] ? 4'h0 : 4'hB);
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta <= 3'b000;
      col_s    <= 3'b000;
    end else begin
      col_meta <= col_in;
      col_s    <= col_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      row_out   <= 4'b0001;
      dwell     <= '0;
      deb       <= '0;
      cap_row   <= 4'b0000;
      cap_col   <= 3'b000;
      key_row   <= 4'b0000;
      key_col   <= 3'b000;
      key_down  <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          // Columns are only trusted on the last dwell cycle, once the row has settled.
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if ($onehot(col_s)) begin
              cap_row <= row_out;
              cap_col <= col_s;
              deb     <= '0;
              state   <= DEBOUNCE;
            end else begin
              row_out <= rotl(row_out);
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (col_s == cap_col) begin
            if (deb == DEB_LAST) begin
              state     <= HELD;
              deb       <= '0;
              key_valid <= 1'b1;
              key_code  <= encode(cap_row, cap_col);
              key_row   <= cap_row;
              key_col   <= cap_col;
              key_down  <= 1'b1;
            end else begin
              deb <= deb + 1'b1;
            end
          end else begin
            state   <= SCAN;
            dwell   <= '0;
            row_out <= rotl(cap_row);
          end
        end
        HELD: begin
          if (col_s != cap_col) begin
            state <= RELEASE;
            deb   <= '0;
          end
        end
        RELEASE: begin
          // Any bounce back to nonzero restarts the quiet-time count; HELD is never re-entered.
          if (col_s == 3'b000) begin
            if (deb == DEB_LAST) begin
              key_row  <= 4'b0000;
              key_col  <= 3'b000;
              key_down <= 1'b0;
              state    <= SCAN;
              dwell    <= '0;
              row_out  <= rotl(cap_row);
            end else begin
              deb <= deb + 1'b1;
            end
          end else begin
            deb <= '0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad drives col_in from row_out,
// a table walks all twelve keys, and hand-timed sequences cover bounce and reset.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic       key_down;
  logic       key_valid;
  logic [3:0] key_code;

  logic [3:0] k_row;
  logic [2:0] k_col;

  int n_vec;
  int n_err;
  int valid_cnt;

  typedef struct {
    logic [3:0] row;
    logic [2:0] col;
    logic [3:0] code;
  } key_t;

  key_t keys [12];

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
    .clk(clk),
    .reset(reset),
    .col_in(col_in),
    .row_out(row_out),
    .key_row(key_row),
    .key_col(key_col),
    .key_down(key_down),
    .key_valid(key_valid),
    .key_code(key_code)
  );

  // Pressed key closes its column only while its own row is driven.
  assign col_in = ((row_out & k_row) != 4'b0000) ? k_col : 3'b000;

  always #5 clk = ~clk;

  function automatic logic [3:0] rot(input logic [3:0] r);
    rot = {r[2:0], r[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_down_fall(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!key_down) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic monitor();
    logic [3:0] prev_row;
    logic       prev_valid;
    bit         row_ok;
    row_ok     = 1'b0;
    prev_valid = 1'b0;
    prev_row   = 4'b0000;
    forever begin
      @(negedge clk);
      if (reset) begin
        row_ok     = 1'b0;
        prev_valid = 1'b0;
      end else begin
        check("row_onehot", 32'($onehot(row_out)), 32'd1);
        if (row_ok && row_out != prev_row)
          check("row_rotate", 32'(row_out), 32'(rot(prev_row)));
        if (key_valid) begin
          valid_cnt++;
          check("valid_not_back_to_back", 32'(prev_valid), 32'd0);
        end
        prev_valid = key_valid;
        prev_row   = row_out;
        row_ok     = 1'b1;
      end
    end
  endtask

  initial begin
    bit got;
    int v0;
    logic [3:0] r;

    keys[0]  = '{4'b0001, 3'b001, 4'h1};
    keys[1]  = '{4'b0001, 3'b010, 4'h2};
    keys[2]  = '{4'b0001, 3'b100, 4'h3};
    keys[3]  = '{4'b0010, 3'b001, 4'h4};
    keys[4]  = '{4'b0010, 3'b010, 4'h5};
    keys[5]  = '{4'b0010, 3'b100, 4'h6};
    keys[6]  = '{4'b0100, 3'b001, 4'h7};
    keys[7]  = '{4'b0100, 3'b010, 4'h8};
    keys[8]  = '{4'b0100, 3'b100, 4'h9};
    keys[9]  = '{4'b1000, 3'b001, 4'hA};
    keys[10] = '{4'b1000, 3'b010, 4'h0};
    keys[11] = '{4'b1000, 3'b100, 4'hB};

    n_vec = 0;
    n_err = 0;
    valid_cnt = 0;
    reset = 1'b1;
    k_row = 4'b0000;
    k_col = 3'b000;
    fork
      monitor();
    join_none

    // Reset state
    tick(3);
    check("rst_row_out", 32'(row_out), 32'h1);
    check("rst_key_row", 32'(key_row), 32'h0);
    check("rst_key_col", 32'(key_col), 32'h0);
    check("rst_key_down", 32'(key_down), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_code", 32'(key_code), 32'h0);
    reset = 1'b0;
    tick(2);

    // Single press of key 5, held, then released with exact release timing
    v0 = valid_cnt;
    k_row = 4'b0010;
    k_col = 3'b010;
    wait_valid(60, got);
    check("k5_valid_seen", 32'(got), 32'd1);
    check("k5_code", 32'(key_code), 32'h5);
    check("k5_row_out_frozen", 32'(row_out), 32'h2);
    tick(80);
    check("k5_one_pulse", 32'(valid_cnt - v0), 32'd1);
    check("k5_key_row", 32'(key_row), 32'h2);
    check("k5_key_col", 32'(key_col), 32'h2);
    check("k5_key_down", 32'(key_down), 32'd1);
    k_row = 4'b0000;
    k_col = 3'b000;
    tick(10);
    check("k5_row_still_held", 32'(key_row), 32'h2);
    check("k5_col_still_held", 32'(key_col), 32'h2);
    tick(1);
    check("k5_row_cleared", 32'(key_row), 32'h0);
    check("k5_col_cleared", 32'(key_col), 32'h0);
    check("k5_down_cleared", 32'(key_down), 32'd0);
    check("k5_code_retained", 32'(key_code), 32'h5);
    tick(3);

    // Bouncing '#': no acceptance during bounce, one after it settles
    v0 = valid_cnt;
    k_row = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      k_col = (i % 2 == 0) ? 3'b100 : 3'b000;
      tick(3);
    end
    tick(2);
    check("hash_no_valid_bounce", 32'(valid_cnt - v0), 32'd0);
    k_col = 3'b100;
    wait_valid(100, got);
    check("hash_valid_seen", 32'(got), 32'd1);
    check("hash_code", 32'(key_code), 32'hB);
    check("hash_key_row", 32'(key_row), 32'h8);
    check("hash_key_col", 32'(key_col), 32'h4);
    k_row = 4'b0000;
    k_col = 3'b000;
    wait_down_fall(40, got);
    check("hash_release_seen", 32'(got), 32'd1);
    tick(3);

    // Release bounce on key 1
    k_row = 4'b0001;
    k_col = 3'b001;
    wait_valid(60, got);
    check("k1_valid_seen", 32'(got), 32'd1);
    check("k1_code", 32'(key_code), 32'h1);
    tick(5);
    v0 = valid_cnt;
    for (int i = 0; i < 4; i++) begin
      k_col = 3'b000;
      tick(5);
      check("k1_down_during_drop", 32'(key_down), 32'd1);
      k_col = 3'b001;
      tick(5);
      check("k1_down_during_raise", 32'(key_down), 32'd1);
    end
    k_col = 3'b000;
    tick(9);
    check("k1_down_before_final", 32'(key_down), 32'd1);
    tick(1);
    check("k1_down_fell", 32'(key_down), 32'd0);
    check("k1_no_second_valid", 32'(valid_cnt - v0), 32'd0);
    k_row = 4'b0000;
    tick(3);

    // Scan coverage: every key in order
    for (int i = 0; i < 12; i++) begin
      k_row = keys[i].row;
      k_col = keys[i].col;
      wait_valid(100, got);
      check($sformatf("scan_valid_%0d", i), 32'(got), 32'd1);
      check($sformatf("scan_code_%0d", i), 32'(key_code), 32'(keys[i].code));
      check($sformatf("scan_key_row_%0d", i), 32'(key_row), 32'(keys[i].row));
      check($sformatf("scan_key_col_%0d", i), 32'(key_col), 32'(keys[i].col));
      check($sformatf("scan_row_out_%0d", i), 32'(row_out), 32'(keys[i].row));
      tick(5);
      k_row = 4'b0000;
      k_col = 3'b000;
      wait_down_fall(40, got);
      check($sformatf("scan_release_%0d", i), 32'(got), 32'd1);
      check($sformatf("scan_row_clr_%0d", i), 32'(key_row), 32'h0);
      check($sformatf("scan_col_clr_%0d", i), 32'(key_col), 32'h0);
      check($sformatf("scan_code_kept_%0d", i), 32'(key_code), 32'(keys[i].code));
      tick(3);
    end

    // Two columns on one row: never captured, scanning continues
    v0 = valid_cnt;
    k_row = 4'b0010;
    k_col = 3'b011;
    for (int i = 0; i < 8; i++) begin
      r = row_out;
      tick(SCAN_DIV);
      check("two_col_rotates", 32'(row_out), 32'(rot(r)));
    end
    check("two_col_no_down", 32'(key_down), 32'd0);
    check("two_col_no_valid", 32'(valid_cnt - v0), 32'd0);
    k_row = 4'b0000;
    k_col = 3'b000;
    tick(3);

    // Reset while key 7 is held, then re-acceptance with exact latency
    k_row = 4'b0100;
    k_col = 3'b001;
    wait_valid(60, got);
    check("k7_valid_seen", 32'(got), 32'd1);
    check("k7_code", 32'(key_code), 32'h7);
    tick(10);
    reset = 1'b1;
    #1;
    check("k7_rst_row_out", 32'(row_out), 32'h1);
    check("k7_rst_key_row", 32'(key_row), 32'h0);
    check("k7_rst_key_col", 32'(key_col), 32'h0);
    check("k7_rst_key_down", 32'(key_down), 32'd0);
    check("k7_rst_key_valid", 32'(key_valid), 32'd0);
    check("k7_rst_key_code", 32'(key_code), 32'h0);
    tick(3);
    reset = 1'b0;
    tick(19);
    check("k7_no_valid_early", 32'(key_valid), 32'd0);
    tick(1);
    check("k7_revalid", 32'(key_valid), 32'd1);
    check("k7_recode", 32'(key_code), 32'h7);
    check("k7_rerow", 32'(key_row), 32'h4);
    check("k7_recol", 32'(key_col), 32'h1);
    tick(1);
    check("k7_valid_one_cycle", 32'(key_valid), 32'd0);
    k_row = 4'b0000;
    k_col = 3'b000;
    wait_down_fall(40, got);
    check("k7_release_seen", 32'(got), 32'd1);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Upstream front end of the safe: drives the 4x3 keypad rows one at a time and samples the raw column lines. It debounces each press and produces clean, held row/column levels plus a single-cycle key event with its code. The held levels feed the safe's `row1..row4` and `col1..col3` inputs directly, so the safe's key detection and BCD encoding see one glitch-free press per physical keystroke.

## Interface
- `SCAN_DIV`, default 16: clock cycles each row is driven. Must be at least 4.
- `DEBOUNCE_CNT`, default 1000: consecutive stable samples needed to accept a press or a release. Must be at least 1.
- `clk`  input  1  system clock; the block's only clock.
- `reset`  input  1  asynchronous, active-high reset.
- `col_in`  input  3  raw keypad columns, active-high, asynchronous to `clk`. Bit 0 is col1.
- `row_out`  output  4  one-hot row drive to the keypad. Bit 0 is row1.
- `key_row`  output  4  one-hot row of the accepted key. High while the key is held, otherwise 0.
- `key_col`  output  3  one-hot column of the accepted key. High while the key is held, otherwise 0.
- `key_down`  output  1  high while an accepted key is held.
- `key_valid`  output  1  one-cycle pulse when a press is accepted.
- `key_code`  output  4  code of the last accepted key:
  - row1 = 1, 2, 3
  - row2 = 4, 5, 6
  - row3 = 7, 8, 9
  - row4 = `*` (4'hA), 0 (4'h0), `#` (4'hB)

## Operation
- Input synchronizer: `col_in` passes through a 2-flop synchronizer to give `col_s`. Only `col_s` is used internally.
- Reset state (asynchronous): state = SCAN, `row_out` = 4'b0001, dwell counter = 0, debounce counter = 0, synchronizer flops = 0. All `key_*` outputs = 0.
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - The dwell counter counts 0 to SCAN_DIV-1.
  - At the last dwell cycle, `col_s` is sampled and `row_out` rotates left. Row 4 wraps to row 1.
  - If the sample has exactly one bit set: capture `row_out` (the pre-rotation value) and `col_s`, freeze rotation (`row_out` stays on the captured row), and go to DEBOUNCE.
  - If the sample is zero or has more than one bit set: keep scanning.
- DEBOUNCE:
  - Each cycle with `col_s` == captured column increments the counter.
  - Any mismatching cycle returns to SCAN. Rotation resumes at the row after the captured row, and the dwell counter restarts at 0.
  - When the counter reaches DEBOUNCE_CNT, go to HELD. In the same transition, pulse `key_valid` for 1 cycle, load `key_code`, drive `key_row`/`key_col` from the captured values, and set `key_down`.
- HELD:
  - Outputs are held while `col_s` equals the captured column.
  - Any other `col_s` value, including a different nonzero value, goes to RELEASE with the debounce counter cleared.
- RELEASE:
  - Counts consecutive cycles with `col_s` == 0. Any nonzero cycle clears the counter. The block never re-enters HELD.
  - When the counter reaches DEBOUNCE_CNT: clear `key_row`, `key_col` and `key_down`, then return to SCAN on the next row.
- `key_code` retains its value after release. It is only updated on `key_valid`.
- Only one key is accepted at a time. Presses on other rows are invisible because only the captured row is driven.
- The dwell counter is width ceil(log2(SCAN_DIV)). The debounce counter is width ceil(log2(DEBOUNCE_CNT+1)). Neither counter wraps. Each is cleared on every state entry.

## Timing
- `col_in` to `col_s` latency: 2 cycles.
- Sampling only at the last dwell cycle (requires SCAN_DIV ≥ 4) guarantees that the columns reflect the current row after a row switch.
- Press acceptance: `key_valid` asserts DEBOUNCE_CNT cycles after the SCAN sample edge, provided the press is stable.
- Release: `key_down` falls DEBOUNCE_CNT cycles after the first zero `col_s` in an uninterrupted run of zeros.
- `key_valid` is never asserted in two consecutive cycles. There is at most one pulse per HELD entry.
- Reset mid-operation: all outputs return to their reset values immediately, with no pulse. A key still held after reset deasserts is accepted again as a new press.

## Test plan
- Single press (SCAN_DIV=4, DEBOUNCE_CNT=8), key 5 (row2/col2) held for 100 cycles, then released:
  - exactly one `key_valid`, `key_code` = 4'h5;
  - `key_row` = 4'b0010 and `key_col` = 3'b010 until 8 cycles after `col_s` goes to 0.
- Bounce, key `#`: toggle col3 every 3 cycles for 30 cycles, then hold:
  - no `key_valid` during bouncing;
  - one `key_valid` after stabilizing, `key_code` = 4'hB.
- Release bounce: while key 1 is HELD, drop and raise col1 every 5 cycles, then hold 0:
  - `key_down` stays 1 throughout the bounces;
  - `key_down` falls 8 cycles after the final drop;
  - no second `key_valid`.
- Scan coverage: press and release keys 1 through 9, then `*`, 0, `#`:
  - codes 1 through 9, then A, 0, B in order;
  - `row_out` is always one-hot and visits 0001, 0010, 0100, 1000 cyclically.
- Two columns pressed on the same row (col1 and col2 both high): no capture, and `row_out` continues to rotate.
- Reset while HELD on key 7: `key_*` = 0 and `row_out` = 0001 immediately. The key is still held after reset deasserts, so it is re-accepted with `key_code` = 4'h7 and a fresh `key_valid`.
